// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: source encodings, in-flight tag, arbiter states.
package mem_port_arbiter_pkg;

    typedef enum logic {
        SRC_IFETCH = 1'b0,
        SRC_DMEM   = 1'b1
    } src_e;

    typedef struct packed {
        src_e src;
        logic discard;
    } tag_t;

    typedef enum logic {
        StIdle   = 1'b0,
        StLocked = 1'b1
    } arb_state_e;

    // Width needed to hold a count from 0 to depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-flight tag FIFO: one tag per accepted memory request, popped on each in-order response.
module mem_arb_tag_fifo
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned Depth = 2,
    localparam int unsigned CntW = cnt_width(Depth),
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push,
    input  tag_t            push_tag,
    input  logic            pop,
    input  logic            clr_ifetch,
    output tag_t            head,
    output logic [CntW-1:0] count
);

    tag_t            mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop & (count_q != '0);
    assign do_push = push & ((count_q != CntW'(Depth)) | do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '{src: SRC_IFETCH, discard: 1'b0};
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Flush marks every fetch tag; a push in the same cycle is never a fetch.
            for (int unsigned i = 0; i < Depth; i++) begin
                if (clr_ifetch && mem_q[i].src == SRC_IFETCH) begin
                    mem_q[i].discard <= 1'b1;
                end
            end
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_tag;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and LSU, routing in-order responses via a tag FIFO.
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        ifetch_rd_i,
    input  logic [31:0] ifetch_addr_i,
    input  logic        ifetch_flush_i,
    output logic        ifetch_accept_o,
    output logic        ifetch_valid_o,
    output logic [31:0] ifetch_data_o,
    output logic        ifetch_error_o,

    input  logic        dmem_rd_i,
    input  logic [3:0]  dmem_wr_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_data_wr_i,
    output logic        dmem_accept_o,
    output logic        dmem_ack_o,
    output logic [31:0] dmem_data_rd_o,
    output logic        dmem_error_o,

    output logic        mem_rd_o,
    output logic [3:0]  mem_wr_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_wr_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_rd_i,
    input  logic        mem_error_i,

    output logic        busy_o
);

    localparam int unsigned CntW = cnt_width(OUTSTANDING);

    arb_state_e      state_q, state_d;
    src_e            owner_q, owner_d;
    src_e            gnt_src;
    logic            gnt_valid, xfer, full;
    logic            if_req, dm_req, ack_valid, drop;
    logic [CntW-1:0] count;
    tag_t            head;

`ifdef MEM_ARB_RR_EN
    src_e last_winner_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_winner_q <= SRC_IFETCH;
        end else if (xfer) begin
            last_winner_q <= gnt_src;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            owner_q <= SRC_IFETCH;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Count is registered, so an ack in a full cycle only frees a slot next cycle.
    assign full = (count == CntW'(OUTSTANDING));

    always_comb begin
        if_req    = ifetch_rd_i & ~ifetch_flush_i;
        dm_req    = dmem_rd_i | (|dmem_wr_i);
        gnt_valid = 1'b0;
        gnt_src   = SRC_IFETCH;
        state_d   = StIdle;
        owner_d   = owner_q;

        if (!full) begin
            // A flush breaks a fetch lock and arbitration falls back to the idle path.
            if (state_q == StLocked && !(owner_q == SRC_IFETCH && ifetch_flush_i)) begin
                gnt_src   = owner_q;
                gnt_valid = (owner_q == SRC_DMEM) ? dm_req : if_req;
            end else if (dm_req && if_req) begin
                gnt_valid = 1'b1;
`ifdef MEM_ARB_RR_EN
                gnt_src   = (last_winner_q == SRC_DMEM) ? SRC_IFETCH : SRC_DMEM;
`else
                gnt_src   = SRC_DMEM;
`endif
            end else if (dm_req) begin
                gnt_valid = 1'b1;
                gnt_src   = SRC_DMEM;
            end else if (if_req) begin
                gnt_valid = 1'b1;
                gnt_src   = SRC_IFETCH;
            end
        end

        xfer = gnt_valid & mem_accept_i;

        if (gnt_valid && !mem_accept_i) begin
            state_d = StLocked;
            owner_d = gnt_src;
        end
    end

    always_comb begin
        mem_rd_o        = 1'b0;
        mem_wr_o        = 4'b0;
        mem_addr_o      = 32'b0;
        mem_data_wr_o   = 32'b0;
        ifetch_accept_o = 1'b0;
        dmem_accept_o   = 1'b0;
        if (gnt_valid) begin
            if (gnt_src == SRC_DMEM) begin
                mem_rd_o      = dmem_rd_i;
                mem_wr_o      = dmem_wr_i;
                mem_addr_o    = dmem_addr_i;
                mem_data_wr_o = dmem_data_wr_i;
                dmem_accept_o = mem_accept_i;
            end else begin
                mem_rd_o        = 1'b1;
                mem_addr_o      = ifetch_addr_i;
                ifetch_accept_o = mem_accept_i;
            end
        end
    end

    mem_arb_tag_fifo #(
        .Depth (OUTSTANDING)
    ) u_tag_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push       (xfer),
        .push_tag   ('{src: gnt_src, discard: 1'b0}),
        .pop        (ack_valid),
        .clr_ifetch (ifetch_flush_i),
        .head       (head),
        .count      (count)
    );

    // Acks with nothing in flight are protocol violations and are dropped.
    assign ack_valid = mem_ack_i & (count != '0);
    assign drop      = head.discard | ifetch_flush_i;

    assign dmem_ack_o     = ack_valid & (head.src == SRC_DMEM);
    assign ifetch_valid_o = ack_valid & (head.src == SRC_IFETCH) & ~drop;
    assign dmem_data_rd_o = mem_data_rd_i;
    assign ifetch_data_o  = mem_data_rd_i;
    assign dmem_error_o   = dmem_ack_o & mem_error_i;
    assign ifetch_error_o = ifetch_valid_o & mem_error_i;

    assign busy_o = (count != '0);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (OUTSTANDING=2); round-robin checks follow MEM_ARB_RR_EN.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ifetch_rd_i, ifetch_flush_i;
    logic [31:0] ifetch_addr_i;
    logic        ifetch_accept_o, ifetch_valid_o, ifetch_error_o;
    logic [31:0] ifetch_data_o;
    logic        dmem_rd_i;
    logic [3:0]  dmem_wr_i;
    logic [31:0] dmem_addr_i, dmem_data_wr_i;
    logic        dmem_accept_o, dmem_ack_o, dmem_error_o;
    logic [31:0] dmem_data_rd_o;
    logic        mem_rd_o;
    logic [3:0]  mem_wr_o;
    logic [31:0] mem_addr_o, mem_data_wr_o;
    logic        mem_accept_i, mem_ack_i, mem_error_i;
    logic [31:0] mem_data_rd_i;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(
        .OUTSTANDING (2)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ifetch_rd_i     (ifetch_rd_i),
        .ifetch_addr_i   (ifetch_addr_i),
        .ifetch_flush_i  (ifetch_flush_i),
        .ifetch_accept_o (ifetch_accept_o),
        .ifetch_valid_o  (ifetch_valid_o),
        .ifetch_data_o   (ifetch_data_o),
        .ifetch_error_o  (ifetch_error_o),
        .dmem_rd_i       (dmem_rd_i),
        .dmem_wr_i       (dmem_wr_i),
        .dmem_addr_i     (dmem_addr_i),
        .dmem_data_wr_i  (dmem_data_wr_i),
        .dmem_accept_o   (dmem_accept_o),
        .dmem_ack_o      (dmem_ack_o),
        .dmem_data_rd_o  (dmem_data_rd_o),
        .dmem_error_o    (dmem_error_o),
        .mem_rd_o        (mem_rd_o),
        .mem_wr_o        (mem_wr_o),
        .mem_addr_o      (mem_addr_o),
        .mem_data_wr_o   (mem_data_wr_o),
        .mem_accept_i    (mem_accept_i),
        .mem_ack_i       (mem_ack_i),
        .mem_data_rd_i   (mem_data_rd_i),
        .mem_error_i     (mem_error_i),
        .busy_o          (busy_o)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic exp_dmem;
        rst_i = 1'b1;
        ifetch_rd_i = 1'b0; ifetch_addr_i = 32'h0; ifetch_flush_i = 1'b0;
        dmem_rd_i = 1'b0; dmem_wr_i = 4'h0; dmem_addr_i = 32'h0; dmem_data_wr_i = 32'h0;
        mem_accept_i = 1'b0; mem_ack_i = 1'b0; mem_data_rd_i = 32'h0; mem_error_i = 1'b0;

        // Reset state
        #3;
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_mem_rd", mem_rd_o, 1'b0);
        chk32("rst_mem_addr", mem_addr_o, 32'h0);
        chk1("rst_if_acc", ifetch_accept_o, 1'b0);
        chk1("rst_dm_acc", dmem_accept_o, 1'b0);
        chk1("rst_if_valid", ifetch_valid_o, 1'b0);
        chk1("rst_dm_ack", dmem_ack_o, 1'b0);
        tick();
        tick();
        rst_i = 1'b0;

        // Fixed priority: LSU before fetch, responses routed in order
        ifetch_rd_i = 1'b1; ifetch_addr_i = 32'h100;
        dmem_rd_i = 1'b1; dmem_addr_i = 32'h200; mem_accept_i = 1'b1;
        settle();
        chk1("prio_dm_acc", dmem_accept_o, 1'b1);
        chk1("prio_if_acc0", ifetch_accept_o, 1'b0);
        chk32("prio_addr0", mem_addr_o, 32'h200);
        chk1("prio_rd0", mem_rd_o, 1'b1);
        tick();
        dmem_rd_i = 1'b0;
        settle();
        chk1("prio_if_acc1", ifetch_accept_o, 1'b1);
        chk32("prio_addr1", mem_addr_o, 32'h100);
        chk1("prio_busy", busy_o, 1'b1);
        tick();
        ifetch_rd_i = 1'b0; mem_accept_i = 1'b0;
        mem_ack_i = 1'b1; mem_data_rd_i = 32'h11111111;
        settle();
        chk1("resp0_dm_ack", dmem_ack_o, 1'b1);
        chk1("resp0_if_valid", ifetch_valid_o, 1'b0);
        chk32("resp0_data", dmem_data_rd_o, 32'h11111111);
        tick();
        mem_data_rd_i = 32'h22222222;
        settle();
        chk1("resp1_if_valid", ifetch_valid_o, 1'b1);
        chk1("resp1_dm_ack", dmem_ack_o, 1'b0);
        chk32("resp1_data", ifetch_data_o, 32'h22222222);
        chk1("resp1_if_err", ifetch_error_o, 1'b0);
        tick();
        mem_ack_i = 1'b0;
        settle();
        chk1("prio_idle", busy_o, 1'b0);

        // Lock: fetch stalled three cycles while LSU requests
        ifetch_rd_i = 1'b1; ifetch_addr_i = 32'h300; mem_accept_i = 1'b0;
        settle();
        chk32("lock_c1_addr", mem_addr_o, 32'h300);
        chk1("lock_c1_if_acc", ifetch_accept_o, 1'b0);
        tick();
        dmem_wr_i = 4'hF; dmem_addr_i = 32'h400; dmem_data_wr_i = 32'hCAFEF00D;
        settle();
        chk32("lock_c2_addr", mem_addr_o, 32'h300);
        chk1("lock_c2_dm_acc", dmem_accept_o, 1'b0);
        chk32("lock_c2_wr", {28'h0, mem_wr_o}, 32'h0);
        tick();
        settle();
        chk32("lock_c3_addr", mem_addr_o, 32'h300);
        tick();
        mem_accept_i = 1'b1;
        settle();
        chk1("lock_c4_if_acc", ifetch_accept_o, 1'b1);
        chk1("lock_c4_dm_acc", dmem_accept_o, 1'b0);
        tick();
        ifetch_rd_i = 1'b0;
        settle();
        chk1("lock_c5_dm_acc", dmem_accept_o, 1'b1);
        chk32("lock_c5_wr", {28'h0, mem_wr_o}, 32'hF);
        chk32("lock_c5_wdata", mem_data_wr_o, 32'hCAFEF00D);
        chk32("lock_c5_addr", mem_addr_o, 32'h400);
        tick();
        dmem_wr_i = 4'h0; mem_accept_i = 1'b0;
        mem_ack_i = 1'b1; mem_data_rd_i = 32'hAAAA5555;
        settle();
        chk1("lock_resp_if", ifetch_valid_o, 1'b1);
        tick();
        settle();
        chk1("lock_resp_dm", dmem_ack_o, 1'b1);
        tick();
        mem_ack_i = 1'b0;
        settle();
        chk1("lock_idle", busy_o, 1'b0);

        // Full: third request held off until an ack frees a slot
        dmem_rd_i = 1'b1; dmem_addr_i = 32'h10; mem_accept_i = 1'b1;
        settle();
        chk1("full_acc0", dmem_accept_o, 1'b1);
        tick();
        dmem_addr_i = 32'h14;
        tick();
        dmem_addr_i = 32'h18;
        settle();
        chk1("full_no_grant", dmem_accept_o, 1'b0);
        chk1("full_no_rd", mem_rd_o, 1'b0);
        chk32("full_no_addr", mem_addr_o, 32'h0);
        mem_ack_i = 1'b1; mem_error_i = 1'b1;
        settle();
        chk1("full_ack_same", dmem_accept_o, 1'b0);
        chk1("full_ack", dmem_ack_o, 1'b1);
        chk1("full_err", dmem_error_o, 1'b1);
        tick();
        mem_ack_i = 1'b0; mem_error_i = 1'b0;
        settle();
        chk1("full_resume", dmem_accept_o, 1'b1);
        chk32("full_resume_addr", mem_addr_o, 32'h18);
        tick();
        dmem_rd_i = 1'b0; mem_accept_i = 1'b0; mem_ack_i = 1'b1;
        tick();
        tick();
        mem_ack_i = 1'b0;
        settle();
        chk1("full_idle", busy_o, 1'b0);

        // Flush: in-flight fetch responses dropped, fetch masked
        ifetch_rd_i = 1'b1; ifetch_addr_i = 32'h500; mem_accept_i = 1'b1;
        tick();
        ifetch_addr_i = 32'h504;
        tick();
        ifetch_addr_i = 32'h508; ifetch_flush_i = 1'b1;
        settle();
        chk1("flush_mask", ifetch_accept_o, 1'b0);
        chk1("flush_no_rd", mem_rd_o, 1'b0);
        tick();
        ifetch_flush_i = 1'b0; ifetch_rd_i = 1'b0; mem_accept_i = 1'b0;
        mem_ack_i = 1'b1; mem_data_rd_i = 32'h12345678;
        settle();
        chk1("flush_drop0", ifetch_valid_o, 1'b0);
        tick();
        settle();
        chk1("flush_drop1", ifetch_valid_o, 1'b0);
        tick();
        mem_ack_i = 1'b0;
        ifetch_rd_i = 1'b1; ifetch_addr_i = 32'h600; mem_accept_i = 1'b1;
        settle();
        chk1("flush_new_acc", ifetch_accept_o, 1'b1);
        tick();
        ifetch_rd_i = 1'b0; mem_accept_i = 1'b0;
        mem_ack_i = 1'b1; mem_data_rd_i = 32'hDEADBEEF;
        settle();
        chk1("flush_new_valid", ifetch_valid_o, 1'b1);
        chk32("flush_new_data", ifetch_data_o, 32'hDEADBEEF);
        tick();
        mem_ack_i = 1'b0;

        // Flush in the same cycle as the fetch ack suppresses it
        ifetch_rd_i = 1'b1; ifetch_addr_i = 32'h700; mem_accept_i = 1'b1;
        tick();
        ifetch_rd_i = 1'b0; mem_accept_i = 1'b0;
        mem_ack_i = 1'b1; ifetch_flush_i = 1'b1;
        settle();
        chk1("flush_same_pop", ifetch_valid_o, 1'b0);
        tick();
        mem_ack_i = 1'b0; ifetch_flush_i = 1'b0;
        settle();
        chk1("flush_same_idle", busy_o, 1'b0);

        // Flush breaks a fetch lock; LSU is granted that cycle
        ifetch_rd_i = 1'b1; ifetch_addr_i = 32'h800; mem_accept_i = 1'b0;
        tick();
        ifetch_flush_i = 1'b1; dmem_rd_i = 1'b1; dmem_addr_i = 32'h900; mem_accept_i = 1'b1;
        settle();
        chk1("unlock_dm_acc", dmem_accept_o, 1'b1);
        chk1("unlock_if_acc", ifetch_accept_o, 1'b0);
        tick();
        ifetch_flush_i = 1'b0; dmem_rd_i = 1'b0;
        settle();
        chk1("unlock_if_after", ifetch_accept_o, 1'b1);
        tick();
        ifetch_rd_i = 1'b0; mem_accept_i = 1'b0; mem_ack_i = 1'b1;
        tick();
        tick();
        mem_ack_i = 1'b0;

        // Ack with nothing in flight is ignored
        mem_ack_i = 1'b1;
        settle();
        chk1("spur_dm_ack", dmem_ack_o, 1'b0);
        chk1("spur_if_valid", ifetch_valid_o, 1'b0);
        tick();
        mem_ack_i = 1'b0;
        settle();
        chk1("spur_busy", busy_o, 1'b0);

        // Both pending continuously: alternation with RR, LSU always otherwise
        ifetch_rd_i = 1'b1; ifetch_addr_i = 32'hA00;
        dmem_rd_i = 1'b1; dmem_addr_i = 32'hB00;
        mem_accept_i = 1'b1; mem_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_dmem = (i % 2 == 0);
`else
            exp_dmem = 1'b1;
`endif
            settle();
            chk1("both_dm_acc", dmem_accept_o, exp_dmem);
            chk1("both_if_acc", ifetch_accept_o, ~exp_dmem);
            tick();
        end
        ifetch_rd_i = 1'b0; dmem_rd_i = 1'b0; mem_accept_i = 1'b0;
        tick();
        mem_ack_i = 1'b0;
        settle();
        chk1("both_idle", busy_o, 1'b0);

        // Reset mid-flight clears tags; later acks are ignored
        ifetch_rd_i = 1'b1; ifetch_addr_i = 32'hC00; mem_accept_i = 1'b1;
        tick();
        tick();
        ifetch_rd_i = 1'b0; mem_accept_i = 1'b0;
        settle();
        chk1("mid_busy", busy_o, 1'b1);
        rst_i = 1'b1;
        settle();
        chk1("mid_rst_busy", busy_o, 1'b0);
        tick();
        rst_i = 1'b0; mem_ack_i = 1'b1;
        settle();
        chk1("mid_ack0_if", ifetch_valid_o, 1'b0);
        chk1("mid_ack0_dm", dmem_ack_o, 1'b0);
        tick();
        settle();
        chk1("mid_ack1_if", ifetch_valid_o, 1'b0);
        chk1("mid_ack1_dm", dmem_ack_o, 1'b0);
        tick();
        mem_ack_i = 1'b0;
        settle();
        chk1("mid_final_busy", busy_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single external memory port between the instruction-fetch unit and the load/store unit. Grants one requester per cycle, keeps the grant locked while a request waits for the port, and tracks up to `OUTSTANDING` in-flight transactions in a tag FIFO so in-order responses reach the requester that issued them. Fetch responses that were in flight when a pipeline flush occurred are discarded. Sits between the core's fetch/LSU front-ends and the memory bus.

## Interface
- `OUTSTANDING`, 2, maximum in-flight transactions, from 1 to 4
- `clk_i  in  1  clock`
- `rst_i  in  1  reset; asynchronous, active-high`
- `ifetch_rd_i  in  1  fetch read request, held until accepted`
- `ifetch_addr_i  in  32  fetch address`
- `ifetch_flush_i  in  1  pipeline flush; discard pending fetch responses`
- `ifetch_accept_o  out  1  fetch request taken this cycle`
- `ifetch_valid_o  out  1  fetch response valid`
- `ifetch_data_o  out  32  fetch response data`
- `ifetch_error_o  out  1  fetch bus error`
- `dmem_rd_i  in  1  load request, held until accepted`
- `dmem_wr_i  in  4  store byte enables, held until accepted`
- `dmem_addr_i  in  32  LSU address`
- `dmem_data_wr_i  in  32  store data`
- `dmem_accept_o  out  1  LSU request taken this cycle`
- `dmem_ack_o  out  1  LSU response (load data or store done)`
- `dmem_data_rd_o  out  32  load data`
- `dmem_error_o  out  1  LSU bus error`
- `mem_rd_o  out  1  read request to memory`
- `mem_wr_o  out  4  byte enables to memory`
- `mem_addr_o  out  32  address to memory`
- `mem_data_wr_o  out  32  write data to memory`
- `mem_accept_i  in  1  memory accepts the current request`
- `mem_ack_i  in  1  memory response, always returned in order`
- `mem_data_rd_i  in  32  response data`
- `mem_error_i  in  1  response error`
- `busy_o  out  1  one or more transactions in flight`

## Operation
- A request is pending when `ifetch_rd_i` is high, or when `dmem_rd_i` or `|dmem_wr_i` is high. A request transfers when it is granted and `mem_accept_i` is high.
- **Arbitration state machine:**
  - IDLE: chooses the winner combinationally. The LSU wins over fetch.
  - IDLE moves to LOCKED when the granted request does not transfer. In LOCKED the owner is held.
  - LOCKED moves back to IDLE on the cycle that request transfers.
- **FIFO full:** when the in-flight count equals `OUTSTANDING`, no grant is made and no `mem_*` request is driven. An ack arriving in the same cycle does not release this block; the new grant comes in the next cycle.
- **On transfer:** push the tag `{src, discard=0}`.
- **On `mem_ack_i`:** pop the head tag.
  - src=LSU: `dmem_ack_o=1`.
  - src=IFETCH and discard=0: `ifetch_valid_o=1`.
  - src=IFETCH and discard=1: the response is dropped silently.
  - Data and error pass straight through.
- **Push and pop in the same cycle:** the count is unchanged.
- **`mem_ack_i` while the count is 0:** ignored and the state is unchanged (protocol violation).
- **`ifetch_flush_i`:**
  - Sets discard on every IFETCH entry in the FIFO, including an entry popped in the same cycle, whose response is suppressed.
  - Masks the fetch grant for that cycle.
  - If fetch holds LOCKED, the lock drops to IDLE.
- **Grant on `mem_*`:** `mem_*` outputs carry the granted requester's fields and are zero when nothing is granted.
- `busy_o = (count != 0)`.

## Timing
- Grant, the `mem_*` request and `*_accept_o` are combinational from the inputs and state. No latency is added.
- Responses are combinational from `mem_ack_i` and the FIFO head. No latency is added.
- **Reset:**
  - count=0, FIFO empty, state IDLE, `last_winner`=IFETCH.
  - Every output reads 0 while the request inputs are 0.
  - Reset in the middle of a transaction clears all tags. Acks that arrive later are ignored.
- **Back-to-back transfers:** a new grant can transfer every cycle while count < `OUTSTANDING`.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - In IDLE, when both requesters are pending, the one that is not `last_winner` is granted.
  - `last_winner` updates on each transfer.
- `MEM_ARB_RR_EN` undefined: fixed LSU priority. No `last_winner` register exists.

## Structure
- Shared package holds:
  - `SRC_IFETCH`=0 and `SRC_DMEM`=1 source encodings.
  - Tag struct `{src, discard}`.
  - Arbiter state encodings IDLE and LOCKED.
- Sub-module `mem_arb_tag_fifo`:
  - Depth `OUTSTANDING`, with push, pop and count.
  - Broadcast-clear input `clr_ifetch` that sets discard on IFETCH entries.

## Test plan
- **Fixed priority:** both requesters pending with `mem_accept_i`=1 → the LSU transfers first, then fetch; responses are routed in order, LSU then fetch.
- **Lock:** fetch granted with `mem_accept_i`=0 for 3 cycles while the LSU raises a request → the grant stays on fetch, fetch transfers on cycle 4, and the LSU transfers on cycle 5.
- **Full:** `OUTSTANDING`=2 with two transfers and no ack → the third request is not granted; on the ack, the grant resumes the next cycle.
- **Flush:** two fetches in flight, then pulse `ifetch_flush_i` → both acks produce `ifetch_valid_o`=0; a fetch issued after the flush returns 0xDEADBEEF with `ifetch_valid_o`=1.
- **Round-robin (`MEM_ARB_RR_EN`):** both requesters continuously pending → grants alternate LSU, IFETCH, LSU, IFETCH.
- **Reset mid-flight:** assert `rst_i` with count=2, then send 2 acks → no `ifetch_valid_o` or `dmem_ack_o`, and `busy_o`=0.
